// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: branch, ALU, immediate-select and register-ID codes,
// plus the control word that reset and bubbles both load.
package id_ex_stage_pkg;

  localparam logic [1:0] NB  = 2'b00;
  localparam logic [1:0] B   = 2'b01;
  localparam logic [1:0] BE  = 2'b10;
  localparam logic [1:0] BNE = 2'b11;

  localparam logic [3:0] NO_ALU_OP = 4'h0;
  localparam logic [3:0] ADD_SUB   = 4'h1;

  localparam logic [2:0] IM0 = 3'd0;

  // R0-R7 occupy codes 0-7; REG0 is the "no register" code
  localparam logic [3:0] SP   = 4'd8;
  localparam logic [3:0] T    = 4'd9;
  localparam logic [3:0] IH   = 4'd10;
  localparam logic [3:0] RA   = 4'd11;
  localparam logic [3:0] PC   = 4'd12;
  localparam logic [3:0] REG0 = 4'hF;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] branch;
    logic       jump;
    logic [3:0] alu_op;
    logic [2:0] src_get;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{
    alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0, mem_write: 1'b0, mem_read: 1'b0,
    branch: NB, jump: 1'b0, alu_op: NO_ALU_OP, src_get: IM0
  };
  localparam logic [3:0] BUBBLE_REG = REG0;

endpackage

// File: rtl/id_ex_stage_hazard_lu_detect.sv
// Load-use hazard detect: a valid load in EX targets a register that the ID instruction reads.
module hazard_lu_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             lu
);

  logic [REG_W-1:0] none;
  logic             hit1;
  logic             hit2;

  assign none = REG_W'(REG0);
  assign hit1 = (id_rs1 == ex_rd) && (id_rs1 != none);
  assign hit2 = (id_rs2 == ex_rd) && (id_rs2 != none);
  assign lu   = ex_valid && ex_mem_read && (ex_rd != none) && id_valid && (hit1 || hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect kill and global hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic              id_mem_read,
  input  logic [1:0]        id_branch,
  input  logic              id_jump,
  input  logic [3:0]        id_alu_op,
  input  logic [2:0]        id_src_get,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              hold,
  input  logic              redirect,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ex_valid,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic [1:0]        ex_branch,
  output logic              ex_jump,
  output logic [3:0]        ex_alu_op,
  output logic [2:0]        ex_src_get,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [15:0]       bubble_cnt
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_p1;
  logic              vld_p1;
  logic [REG_W-1:0]  rs1_p1, rs2_p1, rd_p1;
  logic [DATA_W-1:0] rdata1_p1, rdata2_p1, imm_p1, pc_p1;
  logic [15:0]       bubble_cnt_p1;
  logic              lu;
  logic              insert_bubble;

  assign id_ctrl = '{
    alu_src: id_alu_src, mem_to_reg: id_mem_to_reg, reg_write: id_reg_write,
    mem_write: id_mem_write, mem_read: id_mem_read, branch: id_branch,
    jump: id_jump, alu_op: id_alu_op, src_get: id_src_get
  };

  hazard_lu_detect #(.REG_W(REG_W)) u_lu (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_rd       (rd_p1),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .lu          (lu)
  );

  // Redirect kills the ID instruction anyway, so a coincident load-use needs no freeze
  assign pc_hold       = hold || (lu && !redirect);
  assign ifid_hold     = pc_hold;
  assign insert_bubble = !hold && (redirect || lu);

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (rst || insert_bubble) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= BUBBLE_CTRL;
      rs1_p1    <= REG_W'(BUBBLE_REG);
      rs2_p1    <= REG_W'(BUBBLE_REG);
      rd_p1     <= REG_W'(BUBBLE_REG);
      rdata1_p1 <= '0;
      rdata2_p1 <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
    end else if (!hold) begin
      vld_p1    <= id_valid;
      ctrl_p1   <= id_ctrl;
      rs1_p1    <= id_rs1;
      rs2_p1    <= id_rs2;
      rd_p1     <= id_rd;
      rdata1_p1 <= id_rdata1;
      rdata2_p1 <= id_rdata2;
      imm_p1    <= id_imm;
      pc_p1     <= id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt_p1 <= '0;
    else if (insert_bubble)
      bubble_cnt_p1 <= bubble_cnt_p1 + 16'd1;
  end

  assign ex_valid      = vld_p1;
  assign ex_alu_src    = ctrl_p1.alu_src;
  assign ex_mem_to_reg = ctrl_p1.mem_to_reg;
  assign ex_reg_write  = ctrl_p1.reg_write;
  assign ex_mem_write  = ctrl_p1.mem_write;
  assign ex_mem_read   = ctrl_p1.mem_read;
  assign ex_branch     = ctrl_p1.branch;
  assign ex_jump       = ctrl_p1.jump;
  assign ex_alu_op     = ctrl_p1.alu_op;
  assign ex_src_get    = ctrl_p1.src_get;
  assign ex_rs1        = rs1_p1;
  assign ex_rs2        = rs2_p1;
  assign ex_rd         = rd_p1;
  assign ex_rdata1     = rdata1_p1;
  assign ex_rdata2     = rdata2_p1;
  assign ex_imm        = imm_p1;
  assign ex_pc         = pc_p1;
  assign bubble_cnt    = bubble_cnt_p1;

endmodule
